// File: rtl/tpu_pkg.sv
// Shared types and constants for the activation-stage sequencer.
package tpu_pkg;

  localparam int ACC_DATA_W         = 32;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } act_seq_state_t;

endpackage

// File: rtl/act_seq_fifo.sv
// Synchronous FIFO with a registered show-ahead head word and registered occupancy count.
module act_seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       not_empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count_q, count_after_pop;
  logic             pop_ok;

  assign pop_ok          = pop && (count_q != '0);
  assign rd_ptr_nxt      = rd_ptr + AW'(pop_ok);
  assign count_after_pop = count_q - CW'(pop_ok);
  assign count           = count_q;
  assign not_empty       = (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Head register: bypass the incoming word when the FIFO would otherwise be empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_after_pop + CW'(push);
      if (count_after_pop == '0) begin
        if (push) dout <= din;
      end else begin
        dout <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/act_seq_ctrl.sv
// Activation-stage sequencer: accumulator reads -> activation unit -> output FIFO -> unified buffer.
// Optional ACT_SEQ_STATS_EN adds relu_zero_cnt (ReLU inputs that clamp to zero).
module act_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_src_addr,
  input  logic [ADDR_W-1:0]     cmd_dst_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  cmd_passthrough,
  output logic                  acc_rd_en,
  output logic [ADDR_W-1:0]     acc_rd_addr,
  input  logic [ACC_DATA_W-1:0] acc_rd_data,
  output logic                  act_valid_in,
  output logic [ACC_DATA_W-1:0] act_data_in,
  output logic                  act_passthrough,
  input  logic                  act_valid_out,
  input  logic [ACC_DATA_W-1:0] act_data_out,
  output logic                  ub_wr_en,
  input  logic                  ub_wr_ready,
  output logic [ADDR_W-1:0]     ub_wr_addr,
  output logic [ACC_DATA_W-1:0] ub_wr_data,
  output logic                  busy,
  output logic                  done
`ifdef ACT_SEQ_STATS_EN
  ,
  output logic [15:0]           relu_zero_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  act_seq_state_t    state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  len_q, rd_cnt, wr_cnt, wr_cnt_nxt;
  logic [1:0]        inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              vld_p1, pass_q;
  logic              accept, credit_ok, last_rd, wr_fire;

  // Credits cover words already in the FIFO plus reads still in the pipeline.
  assign credit_ok  = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign accept     = (state == IDLE) && cmd_valid;
  assign last_rd    = acc_rd_en && (rd_cnt == len_q - LEN_W'(1));
  assign wr_fire    = ub_wr_en && ub_wr_ready;
  assign wr_cnt_nxt = wr_cnt + LEN_W'(wr_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    acc_rd_en = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = (cmd_len != '0) ? RUN : DONE;
      end
      RUN: begin
        acc_rd_en = (rd_cnt < len_q) && credit_ok;
        if (last_rd) state_nxt = DRAIN;
      end
      DRAIN: if (wr_cnt_nxt == len_q) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      pass_q   <= 1'b0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      inflight <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1   <= acc_rd_en;
      inflight <= inflight + 2'(acc_rd_en) - 2'(act_valid_out);
      if (accept) begin
        src_q  <= cmd_src_addr;
        dst_q  <= cmd_dst_addr;
        len_q  <= cmd_len;
        pass_q <= cmd_passthrough;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        rd_cnt <= rd_cnt + LEN_W'(acc_rd_en);
        wr_cnt <= wr_cnt_nxt;
      end
    end
  end

  assign acc_rd_addr     = src_q + ADDR_W'(rd_cnt);
  assign ub_wr_addr      = dst_q + ADDR_W'(wr_cnt);
  assign act_valid_in    = vld_p1;
  assign act_data_in     = acc_rd_data;
  assign act_passthrough = pass_q;

  act_seq_fifo #(
    .WIDTH (ACC_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (act_valid_out),
    .din       (act_data_out),
    .pop       (ub_wr_ready),
    .dout      (ub_wr_data),
    .not_empty (ub_wr_en),
    .count     (fifo_count)
  );

`ifdef ACT_SEQ_STATS_EN
  logic signed [ACC_DATA_W-1:0] act_in_s;
  assign act_in_s = acc_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relu_zero_cnt <= '0;
    end else if (accept) begin
      relu_zero_cnt <= '0;
    end else if (vld_p1 && !pass_q && (act_in_s <= 0) && (relu_zero_cnt != 16'hFFFF)) begin
      relu_zero_cnt <= relu_zero_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_seq_ctrl.sv
// Directed bench for act_seq_ctrl with behavioural accumulator and activation models.
module tb_act_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_passthrough;
  logic [7:0]  cmd_src_addr, cmd_dst_addr, cmd_len;
  logic        acc_rd_en;
  logic [7:0]  acc_rd_addr;
  logic [31:0] acc_rd_data;
  logic        act_valid_in, act_passthrough, act_valid_out;
  logic [31:0] act_data_in, act_data_out;
  logic        ub_wr_en, ub_wr_ready;
  logic [7:0]  ub_wr_addr;
  logic [31:0] ub_wr_data;
  logic        busy, done;
`ifdef ACT_SEQ_STATS_EN
  logic [15:0] relu_zero_cnt;
`endif

  act_seq_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_src_addr    (cmd_src_addr),
    .cmd_dst_addr    (cmd_dst_addr),
    .cmd_len         (cmd_len),
    .cmd_passthrough (cmd_passthrough),
    .acc_rd_en       (acc_rd_en),
    .acc_rd_addr     (acc_rd_addr),
    .acc_rd_data     (acc_rd_data),
    .act_valid_in    (act_valid_in),
    .act_data_in     (act_data_in),
    .act_passthrough (act_passthrough),
    .act_valid_out   (act_valid_out),
    .act_data_out    (act_data_out),
    .ub_wr_en        (ub_wr_en),
    .ub_wr_ready     (ub_wr_ready),
    .ub_wr_addr      (ub_wr_addr),
    .ub_wr_data      (ub_wr_data),
    .busy            (busy),
    .done            (done)
`ifdef ACT_SEQ_STATS_EN
    ,
    .relu_zero_cnt   (relu_zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] acc_mem [256];

  // One-cycle accumulator read and one-cycle activation unit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_rd_data   <= '0;
      act_valid_out <= 1'b0;
      act_data_out  <= '0;
    end else begin
      if (acc_rd_en) acc_rd_data <= acc_mem[acc_rd_addr];
      act_valid_out <= act_valid_in;
      act_data_out  <= (act_passthrough || !act_data_in[31]) ? act_data_in : 32'd0;
    end
  end

  logic [7:0]  rd_q[$];
  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] exp_d[$];
  logic [7:0]  exp_ra[$];
  int          outstanding, max_out, pass_bad;
  logic        exp_pass;

  always @(negedge clk) begin
    if (acc_rd_en) begin
      rd_q.push_back(acc_rd_addr);
      outstanding++;
    end
    if (ub_wr_en && ub_wr_ready) begin
      wa_q.push_back(ub_wr_addr);
      wd_q.push_back(ub_wr_data);
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    if (busy && (act_passthrough !== exp_pass)) pass_bad++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                         input logic pass, output int lat);
    @(posedge clk); #1;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    outstanding = 0; max_out = 0; pass_bad = 0; exp_pass = pass;
    cmd_src_addr = src; cmd_dst_addr = dst; cmd_len = len; cmd_passthrough = pass;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_traffic(input string tag, input logic [7:0] dst);
    logic [7:0] a;
    check({tag, "_nrd"}, 32'(rd_q.size()), 32'(exp_ra.size()));
    foreach (exp_ra[i]) if (i < rd_q.size()) check({tag, "_rdaddr"}, 32'(rd_q[i]), 32'(exp_ra[i]));
    check({tag, "_nwr"}, 32'(wd_q.size()), 32'(exp_d.size()));
    foreach (exp_d[i]) begin
      if (i < wd_q.size()) begin
        a = dst + 8'(i);
        check({tag, "_wraddr"}, 32'(wa_q[i]), 32'(a));
        check({tag, "_wrdata"}, wd_q[i], exp_d[i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(acc_rd_en), 32'd0);
    check({tag, "_act_vld"}, 32'(act_valid_in), 32'd0);
    check({tag, "_act_pt"}, 32'(act_passthrough), 32'd0);
    check({tag, "_wr_en"}, 32'(ub_wr_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(acc_rd_addr), 32'd0);
    check({tag, "_wr_addr"}, 32'(ub_wr_addr), 32'd0);
    check({tag, "_wr_data"}, ub_wr_data, 32'd0);
  endtask

  int lat, n;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_passthrough = 1'b0;
    cmd_src_addr = '0; cmd_dst_addr = '0; cmd_len = '0;
    ub_wr_ready = 1'b1; exp_pass = 1'b0;
    outstanding = 0; max_out = 0; pass_bad = 0;
    for (int i = 0; i < 256; i++) acc_mem[i] = 32'hA000_0000 | 32'(i);
    acc_mem[8'h10] = 32'd5;        acc_mem[8'h11] = 32'hFFFF_FFFD;
    acc_mem[8'h12] = 32'd0;        acc_mem[8'h13] = 32'h7FFF_FFFF;
    acc_mem[8'h20] = 32'hFFFF_FFFF; acc_mem[8'h21] = 32'hFFFF_FFFE;
    acc_mem[8'h22] = 32'd7;
    for (int i = 0; i < 6; i++) acc_mem[8'h30 + i] = 32'h100 + 32'(i);
    acc_mem[8'hFE] = 32'd11; acc_mem[8'hFF] = 32'd22; acc_mem[8'h00] = 32'd33;

    #22;
    check_reset_outputs("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // ReLU, len 4
    run_cmd(8'h10, 8'h40, 8'd4, 1'b0, lat);
    check("t1_done_lat", 32'(lat), 32'd8);
    exp_ra = '{8'h10, 8'h11, 8'h12, 8'h13};
    exp_d  = '{32'd5, 32'd0, 32'd0, 32'h7FFF_FFFF};
    expect_traffic("t1", 8'h40);
    check("t1_pt_hold", 32'(pass_bad), 32'd0);
`ifdef ACT_SEQ_STATS_EN
    check("t1_relu_zero_cnt", 32'(relu_zero_cnt), 32'd2);
`endif
    @(posedge clk); #1;
    check("t1_ready_after", 32'(cmd_ready), 32'd1);
    check("t1_busy_after", 32'(busy), 32'd0);

    // Passthrough, len 3
    run_cmd(8'h20, 8'h50, 8'd3, 1'b1, lat);
    check("t2_done_lat", 32'(lat), 32'd7);
    exp_ra = '{8'h20, 8'h21, 8'h22};
    exp_d  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd7};
    expect_traffic("t2", 8'h50);
    check("t2_pt_hold", 32'(pass_bad), 32'd0);

    // Backpressure: unified buffer stalls 10 cycles from the first write attempt
    ub_wr_ready = 1'b0;
    n = 0;
    fork
      run_cmd(8'h30, 8'h60, 8'd6, 1'b0, lat);
      begin
        while (!ub_wr_en && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
        repeat (10) @(posedge clk);
        #1 ub_wr_ready = 1'b1;
      end
    join
    check("t3_done_seen", 32'(lat > 0), 32'd1);
    check("t3_max_outstanding", 32'(max_out), 32'd4);
    exp_ra = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    exp_d  = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
    expect_traffic("t3", 8'h60);

    // Address wrap
    run_cmd(8'hFE, 8'hFF, 8'd3, 1'b0, lat);
    check("t4_done_lat", 32'(lat), 32'd7);
    exp_ra = '{8'hFE, 8'hFF, 8'h00};
    exp_d  = '{32'd11, 32'd22, 32'd33};
    expect_traffic("t4", 8'hFF);

    // Zero-length no-op
    run_cmd(8'h10, 8'h40, 8'd0, 1'b0, lat);
    check("t5_done_lat", 32'(lat), 32'd1);
    exp_ra.delete();
    exp_d.delete();
    expect_traffic("t5", 8'h40);

    // Reset mid-RUN, then a clean command
    @(posedge clk); #1;
    cmd_src_addr = 8'h30; cmd_dst_addr = 8'h70; cmd_len = 8'd6; cmd_passthrough = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    run_cmd(8'h10, 8'h40, 8'd4, 1'b0, lat);
    check("t6_done_lat", 32'(lat), 32'd8);
    exp_ra = '{8'h10, 8'h11, 8'h12, 8'h13};
    exp_d  = '{32'd5, 32'd0, 32'd0, 32'h7FFF_FFFF};
    expect_traffic("t6", 8'h40);
`ifdef ACT_SEQ_STATS_EN
    check("t6_relu_zero_cnt", 32'(relu_zero_cnt), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
